// File: rtl/tile_writeback_if.sv
// Memory write port of the tile writeback stage: one valid/ready beat per element.
interface tile_writeback_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 8
);
   logic              mem_valid;
   logic              mem_ready;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_data;
   logic              mem_last;

   modport master (
      output mem_valid,
      output mem_addr,
      output mem_data,
      output mem_last,
      input  mem_ready
   );

   modport slave (
      input  mem_valid,
      input  mem_addr,
      input  mem_data,
      input  mem_last,
      output mem_ready
   );
endinterface

// File: rtl/tile_writeback.sv
// Captures a 4x4 result tile on start and drains it as 16 registered write beats.
// Optional XOR checksum of the accepted beats: define TILE_WRITEBACK_CHECKSUM_EN.
//
// state  | meaning
// IDLE   | no tile held; start captures tile_in, base_addr, col_major
// STREAM | presenting beat k on the memory port until the beat-15 handshake
module tile_writeback #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 8,
   parameter int ADDR_STRIDE = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [ADDR_W-1:0]    base_addr,
   input  logic                 col_major,
   input  logic [16*DATA_W-1:0] tile_in,
   tile_writeback_if.master     mem,
   output logic                 busy,
   output logic                 done,
   output logic                 err_drop
`ifdef TILE_WRITEBACK_CHECKSUM_EN
   ,
   output logic [DATA_W-1:0]    checksum
`endif
);

   typedef enum logic {
      S_IDLE   = 1'b0,
      S_STREAM = 1'b1
   } state_t;

   state_t                state_q, state_d;
   logic [16*DATA_W-1:0]  tile_q, tile_d;
   logic                  col_q, col_d;
   logic [3:0]            k_q, k_d;
   logic                  valid_q, valid_d;
   logic [ADDR_W-1:0]     addr_q, addr_d;
   logic [DATA_W-1:0]     data_q, data_d;
   logic                  last_q, last_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;

   logic                  beat_hs;
   logic [3:0]            k_next;
   logic [3:0]            idx_next;

   assign beat_hs = valid_q && mem.mem_ready;
   assign k_next  = k_q + 4'd1;
   // Column-major swaps the row/column halves of the beat number.
   assign idx_next = col_q ? {k_next[1:0], k_next[3:2]} : k_next;

   always_comb begin
      state_d = state_q;
      tile_d  = tile_q;
      col_d   = col_q;
      k_d     = k_q;
      valid_d = valid_q;
      addr_d  = addr_q;
      data_d  = data_q;
      last_d  = last_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               tile_d  = tile_in;
               col_d   = col_major;
               k_d     = 4'd0;
               valid_d = 1'b1;
               addr_d  = base_addr;
               data_d  = tile_in[DATA_W-1:0];
               last_d  = 1'b0;
               busy_d  = 1'b1;
               state_d = S_STREAM;
            end
         end
         S_STREAM: begin
            err_d = start;
            if (beat_hs) begin
               if (k_q == 4'd15) begin
                  valid_d = 1'b0;
                  last_d  = 1'b0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  k_d    = k_next;
                  addr_d = addr_q + ADDR_W'(ADDR_STRIDE);
                  data_d = tile_q[DATA_W*idx_next +: DATA_W];
                  last_d = (k_next == 4'd15);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         tile_q  <= '0;
         col_q   <= 1'b0;
         k_q     <= 4'd0;
         valid_q <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         last_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tile_q  <= tile_d;
         col_q   <= col_d;
         k_q     <= k_d;
         valid_q <= valid_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         last_q  <= last_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign mem.mem_valid = valid_q;
   assign mem.mem_addr  = addr_q;
   assign mem.mem_data  = data_q;
   assign mem.mem_last  = last_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign err_drop      = err_q;

`ifdef TILE_WRITEBACK_CHECKSUM_EN
   logic [DATA_W-1:0] checksum_q, checksum_d;

   always_comb begin
      checksum_d = checksum_q;
      if (state_q == S_IDLE && start) begin
         checksum_d = '0;
      end else if (state_q == S_STREAM && beat_hs) begin
         checksum_d = checksum_q ^ data_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         checksum_q <= '0;
      end else begin
         checksum_q <= checksum_d;
      end
   end

   assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_tile_writeback.sv
// Bench for tile_writeback: directed vector table plus randomized tiles against a beat-queue model.
module tb_tile_writeback;
   localparam int DW    = 32;
   localparam int AW    = 8;
   localparam int LIMIT = 400;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic               start = 1'b0;
   logic               col_major = 1'b0;
   logic [AW-1:0]      base_addr = '0;
   logic [16*DW-1:0]   tile_in = '0;
   logic               busy, done, err_drop;
`ifdef TILE_WRITEBACK_CHECKSUM_EN
   logic [DW-1:0]      checksum;
`endif

   tile_writeback_if #(.DATA_W(DW), .ADDR_W(AW)) mem_if ();

   tile_writeback #(.DATA_W(DW), .ADDR_W(AW), .ADDR_STRIDE(1)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .base_addr (base_addr),
      .col_major (col_major),
      .tile_in   (tile_in),
      .mem       (mem_if),
      .busy      (busy),
      .done      (done),
      .err_drop  (err_drop)
`ifdef TILE_WRITEBACK_CHECKSUM_EN
      ,
      .checksum  (checksum)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic          last;
   } beat_t;

   typedef struct {
      logic          col;
      logic [AW-1:0] base;
      int            mode;
      logic [AW-1:0] a0, a8, a15;
      logic [DW-1:0] d1, d4, d15;
      int            done_c;
   } vec_t;

   beat_t          q[$];
   logic           m_done = 1'b0;
   logic           m_err = 1'b0;
   logic [DW-1:0]  m_csum = '0;

   int passed = 0;
   int total = 0;
   int cyc = 0;

   logic           o_valid = 1'b0, o_last, o_done;
   logic [AW-1:0]  o_addr;
   logic [DW-1:0]  o_data;

   logic [AW-1:0]  log_addr[16];
   logic [DW-1:0]  log_data[16];
   logic           log_last[16];
   int             hs, err_seen, done_rel;

   logic [AW-1:0]  cur_base;
   logic           cur_col;
   logic [16*DW-1:0] cur_tile, fixed_tile;
   vec_t           vecs[4];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic logic [16*DW-1:0] rand_tile();
      logic [16*DW-1:0] t;
      for (int w = 0; w < 16; w++) t[DW*w +: DW] = $urandom;
      return t;
   endfunction

   // Expected beat list straight from the ordering and addressing rules.
   task automatic build(input logic [16*DW-1:0] t, input logic [AW-1:0] b, input logic c);
      beat_t bt;
      int row, col;
      q.delete();
      m_csum = '0;
      for (int k = 0; k < 16; k++) begin
         row = c ? k % 4 : k / 4;
         col = c ? k / 4 : k % 4;
         bt.data = t[DW*(4*row + col) +: DW];
         bt.addr = b + AW'(k);
         bt.last = (k == 15);
         q.push_back(bt);
      end
   endtask

   task automatic observe();
      logic exp_v;
      @(negedge clk);
      o_valid = mem_if.mem_valid;
      o_addr  = mem_if.mem_addr;
      o_data  = mem_if.mem_data;
      o_last  = mem_if.mem_last;
      o_done  = done;
      exp_v   = (q.size() > 0);
      chk("mem_valid", 64'(o_valid), 64'(exp_v));
      chk("busy", 64'(busy), 64'(exp_v));
      chk("done", 64'(o_done), 64'(m_done));
      chk("err_drop", 64'(err_drop), 64'(m_err));
      if (exp_v) begin
         chk("mem_addr", 64'(o_addr), 64'(q[0].addr));
         chk("mem_data", 64'(o_data), 64'(q[0].data));
         chk("mem_last", 64'(o_last), 64'(q[0].last));
      end else begin
         chk("mem_last_idle", 64'(o_last), 64'(0));
      end
`ifdef TILE_WRITEBACK_CHECKSUM_EN
      if (m_done) chk("checksum", 64'(checksum), 64'(m_csum));
`endif
      if (err_drop) err_seen++;
   endtask

   task automatic drive(input logic st, input logic rdy);
      start = st;
      mem_if.mem_ready = rdy;
      base_addr = cur_base;
      col_major = cur_col;
      tile_in = cur_tile;
      if (o_valid && rdy) begin
         if (hs < 16) begin
            log_addr[hs] = o_addr;
            log_data[hs] = o_data;
            log_last[hs] = o_last;
         end
         hs++;
      end
      m_done = 1'b0;
      m_err = 1'b0;
      if (q.size() > 0) begin
         m_err = st;
         if (rdy) begin
            m_csum ^= q[0].data;
            void'(q.pop_front());
            m_done = (q.size() == 0);
         end
      end else if (st) begin
         build(cur_tile, cur_base, cur_col);
      end
      cyc++;
   endtask

   task automatic begin_log();
      hs = 0;
      err_seen = 0;
      done_rel = -1;
      for (int i = 0; i < 16; i++) begin
         log_addr[i] = '0;
         log_data[i] = '0;
         log_last[i] = 1'b0;
      end
   endtask

   task automatic start_tile(input logic c, input logic [AW-1:0] b, input logic [16*DW-1:0] t);
      cur_col = c;
      cur_base = b;
      cur_tile = t;
      observe();
      begin_log();
      drive(1'b1, 1'b1);
   endtask

   // mode 0: ready high, 1: ready 1,0,0,1 repeating, 2: random ready/starts/tile noise
   task automatic stream(input int mode, input int err_at, input int stop_at);
      logic rdy, st;
      for (int c = 1; c <= LIMIT; c++) begin
         observe();
         if (o_done) begin
            done_rel = c;
            return;
         end
         if (c == stop_at) return;
         case (mode)
            0:       rdy = 1'b1;
            1:       rdy = ((c - 1) % 4 == 0) || ((c - 1) % 4 == 3);
            default: rdy = ($urandom_range(0, 99) < 65);
         endcase
         st = (c == err_at) || (mode == 2 && $urandom_range(0, 99) < 4);
         if (st || mode == 2) begin
            cur_tile = rand_tile();
            cur_base = AW'($urandom);
            cur_col  = 1'($urandom_range(0, 1));
         end
         drive(st, rdy);
      end
      total++;
      $display("FAIL stream_timeout: no done within %0d cycles (cycle %0d)", LIMIT, cyc);
   endtask

   initial begin
      int nlast;
      for (int i = 1; i <= 4; i++)
         for (int j = 1; j <= 4; j++)
            fixed_tile[DW*(4*(i-1) + (j-1)) +: DW] = DW'(32'h100 * i + j);

      vecs[0] = '{1'b0, 8'h10, 0, 8'h10, 8'h18, 8'h1F, 32'h102, 32'h201, 32'h404, 17};
      vecs[1] = '{1'b1, 8'h00, 0, 8'h00, 8'h08, 8'h0F, 32'h201, 32'h102, 32'h404, 17};
      vecs[2] = '{1'b0, 8'hF8, 0, 8'hF8, 8'h00, 8'h07, 32'h102, 32'h201, 32'h404, 17};
      vecs[3] = '{1'b0, 8'h20, 1, 8'h20, 8'h28, 8'h2F, 32'h102, 32'h201, 32'h404, 33};

      cur_base = '0;
      cur_col = 1'b0;
      cur_tile = '0;
      mem_if.mem_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_outputs", 64'({mem_if.mem_valid, mem_if.mem_addr, mem_if.mem_data,
                                mem_if.mem_last, busy, done, err_drop}), 64'(0));
      rst = 1'b1;

      for (int v = 0; v < 4; v++) begin
         start_tile(vecs[v].col, vecs[v].base, fixed_tile);
         stream(vecs[v].mode, 0, 0);
         drive(1'b0, 1'b1);
         nlast = 0;
         for (int i = 0; i < 16; i++) nlast += int'(log_last[i]);
         chk("vec_handshakes", 64'(hs), 64'(16));
         chk("vec_addr0", 64'(log_addr[0]), 64'(vecs[v].a0));
         chk("vec_addr8", 64'(log_addr[8]), 64'(vecs[v].a8));
         chk("vec_addr15", 64'(log_addr[15]), 64'(vecs[v].a15));
         chk("vec_data1", 64'(log_data[1]), 64'(vecs[v].d1));
         chk("vec_data4", 64'(log_data[4]), 64'(vecs[v].d4));
         chk("vec_data15", 64'(log_data[15]), 64'(vecs[v].d15));
         chk("vec_last_count", 64'(nlast), 64'(1));
         chk("vec_last_on_15", 64'(log_last[15]), 64'(1));
         chk("vec_done_cycle", 64'(done_rel), 64'(vecs[v].done_c));
      end

      // Start during beat 5, then start again in the done cycle.
      start_tile(1'b0, 8'h40, fixed_tile);
      stream(0, 6, 0);
      chk("err_pulses", 64'(err_seen), 64'(1));
      chk("err_keep_data5", 64'(log_data[5]), 64'(32'h202));
      chk("err_keep_addr15", 64'(log_addr[15]), 64'(8'h4F));
      chk("err_done_cycle", 64'(done_rel), 64'(17));
      cur_base = 8'h80;
      cur_col = 1'b1;
      cur_tile = fixed_tile;
      begin_log();
      drive(1'b1, 1'b1);
      stream(0, 0, 0);
      drive(1'b0, 1'b1);
      chk("b2b_handshakes", 64'(hs), 64'(16));
      chk("b2b_addr0", 64'(log_addr[0]), 64'(8'h80));
      chk("b2b_data1", 64'(log_data[1]), 64'(32'h201));
      chk("b2b_done_cycle", 64'(done_rel), 64'(17));

      // Reset pulse while beat 8 is on the port.
      start_tile(1'b0, 8'h33, fixed_tile);
      stream(0, 0, 9);
      chk("pre_rst_addr", 64'(o_addr), 64'(8'h3B));
      rst = 1'b0;
      #1;
      chk("rst_outputs", 64'({mem_if.mem_valid, mem_if.mem_addr, mem_if.mem_data,
                              mem_if.mem_last, busy, done, err_drop}), 64'(0));
`ifdef TILE_WRITEBACK_CHECKSUM_EN
      chk("rst_checksum", 64'(checksum), 64'(0));
`endif
      q.delete();
      m_done = 1'b0;
      m_err = 1'b0;
      m_csum = '0;
      o_valid = 1'b0;
      drive(1'b0, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      repeat (3) begin
         observe();
         drive(1'b0, 1'b1);
      end
      start_tile(1'b1, 8'h50, fixed_tile);
      stream(0, 0, 0);
      drive(1'b0, 1'b1);
      chk("rst_fresh_handshakes", 64'(hs), 64'(16));
      chk("rst_fresh_addr0", 64'(log_addr[0]), 64'(8'h50));
      chk("rst_fresh_done", 64'(done_rel), 64'(17));

      for (int r = 0; r < 6; r++) begin
         start_tile(1'($urandom_range(0, 1)), AW'($urandom), rand_tile());
         stream(2, 0, 0);
         drive(1'b0, 1'b1);
         chk("rand_handshakes", 64'(hs), 64'(16));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
